// File: rtl/axi_lite_bus_arbiter_pkg.sv
// Shared constants for the two-master AXI4-lite arbiter: grant codes, FSM states, response codes.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package axi_lite_bus_arbiter_pkg;

    localparam int NUM_ARB_MASTERS = 2;

    // One-hot grant encodings; bit index equals master index
    localparam logic [1:0] GRANT_NONE    = 2'b00;
    localparam logic [1:0] IFU_GRANT     = 2'b01;
    localparam logic [1:0] DATAMEM_GRANT = 2'b10;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_RD_ADDR = 3'd1,
        ARB_RD_DATA = 3'd2,
        ARB_WR_ADDR = 3'd3,
        ARB_WR_RESP = 3'd4
    } arb_state_t;

    // AXI response codes; the arbiter passes these through untouched
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXSLV  = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_lite_arb_pick.sv
// Combinational winner selection between IFU (master 0) and LSU (master 1); YSYX_ARB_ROUND_ROBIN_EN enables alternation on ties.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller only samples the result while idle.
module axi_lite_arb_pick
    import axi_lite_bus_arbiter_pkg::*;
(
    input  logic [NUM_ARB_MASTERS-1:0] req,
`ifdef YSYX_ARB_ROUND_ROBIN_EN
    input  logic                       last_owner,
`endif
    output logic [1:0]                 win
);

    // Pick a one-hot winner; ties go to the LSU unless round-robin says the LSU had the bus last
    always_comb begin
        win = GRANT_NONE;
        if (req[1] && req[0]) begin
`ifdef YSYX_ARB_ROUND_ROBIN_EN
            win = last_owner ? IFU_GRANT : DATAMEM_GRANT;
`else
            win = DATAMEM_GRANT;
`endif
        end else if (req[1]) begin
            win = DATAMEM_GRANT;
        end else if (req[0]) begin
            win = IFU_GRANT;
        end
    end

endmodule

// File: rtl/axi_lite_bus_arbiter.sv
// Two-master (IFU, LSU) to one-slave AXI4-lite arbiter holding the grant for one whole transaction; macro YSYX_ARB_ROUND_ROBIN_EN selects round-robin ties.
// Latency: slave sees valid one cycle after the master raises its request; routing is combinational off the registered grant.
// Backpressure: slave ready/valid pass straight to the granted master; the other master sees all ready/valid at 0.
module axi_lite_bus_arbiter
    import axi_lite_bus_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RESP_WIDTH = 2,
    parameter int STRB_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    // master 0: instruction fetch
    input  logic [DATA_WIDTH-1:0] m0_araddr,
    input  logic                  m0_arvalid,
    output logic                  m0_arready,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    output logic [RESP_WIDTH-1:0] m0_rresp,
    output logic                  m0_rvalid,
    input  logic                  m0_rready,
    input  logic [DATA_WIDTH-1:0] m0_awaddr,
    input  logic                  m0_awvalid,
    output logic                  m0_awready,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    input  logic [STRB_WIDTH-1:0] m0_wstrb,
    input  logic                  m0_wvalid,
    output logic                  m0_wready,
    output logic [RESP_WIDTH-1:0] m0_bresp,
    output logic                  m0_bvalid,
    input  logic                  m0_bready,
    // master 1: load/store unit
    input  logic [DATA_WIDTH-1:0] m1_araddr,
    input  logic                  m1_arvalid,
    output logic                  m1_arready,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic [RESP_WIDTH-1:0] m1_rresp,
    output logic                  m1_rvalid,
    input  logic                  m1_rready,
    input  logic [DATA_WIDTH-1:0] m1_awaddr,
    input  logic                  m1_awvalid,
    output logic                  m1_awready,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    input  logic [STRB_WIDTH-1:0] m1_wstrb,
    input  logic                  m1_wvalid,
    output logic                  m1_wready,
    output logic [RESP_WIDTH-1:0] m1_bresp,
    output logic                  m1_bvalid,
    input  logic                  m1_bready,
    // shared slave side
    output logic [DATA_WIDTH-1:0] s_araddr,
    output logic                  s_arvalid,
    input  logic                  s_arready,
    input  logic [DATA_WIDTH-1:0] s_rdata,
    input  logic [RESP_WIDTH-1:0] s_rresp,
    input  logic                  s_rvalid,
    output logic                  s_rready,
    output logic [DATA_WIDTH-1:0] s_awaddr,
    output logic                  s_awvalid,
    input  logic                  s_awready,
    output logic [DATA_WIDTH-1:0] s_wdata,
    output logic [STRB_WIDTH-1:0] s_wstrb,
    output logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic [RESP_WIDTH-1:0] s_bresp,
    input  logic                  s_bvalid,
    output logic                  s_bready,
    output logic [1:0]            grant
);

    arb_state_t                    state;
    logic                          aw_done;
    logic                          w_done;
    logic [NUM_ARB_MASTERS-1:0]    req;
    logic [1:0]                    win;
    logic                          win_arvalid;
    logic                          aw_hs;
    logic                          w_hs;
`ifdef YSYX_ARB_ROUND_ROBIN_EN
    logic                          last_owner;
`endif

    // Signals of whichever master currently owns the bus (zero when nobody does)
    logic [DATA_WIDTH-1:0] own_araddr;
    logic                  own_arvalid;
    logic                  own_rready;
    logic [DATA_WIDTH-1:0] own_awaddr;
    logic                  own_awvalid;
    logic [DATA_WIDTH-1:0] own_wdata;
    logic [STRB_WIDTH-1:0] own_wstrb;
    logic                  own_wvalid;
    logic                  own_bready;

    assign req         = {m1_arvalid | m1_awvalid, m0_arvalid | m0_awvalid};
    assign win_arvalid = win[1] ? m1_arvalid : m0_arvalid;
    assign aw_hs       = s_awvalid && s_awready;
    assign w_hs        = s_wvalid && s_wready;

    axi_lite_arb_pick u_pick (
        .req        (req),
`ifdef YSYX_ARB_ROUND_ROBIN_EN
        .last_owner (last_owner),
`endif
        .win        (win)
    );

    // Transaction FSM: grant is captured in IDLE and held until the final response handshake
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            grant      <= GRANT_NONE;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
`ifdef YSYX_ARB_ROUND_ROBIN_EN
            last_owner <= 1'b0;
`endif
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (win != GRANT_NONE) begin
                        grant   <= win;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        // a master asking for both gets its read serviced first
                        state   <= win_arvalid ? ARB_RD_ADDR : ARB_WR_ADDR;
                    end
                end
                ARB_RD_ADDR: begin
                    if (s_arvalid && s_arready) begin
                        state <= ARB_RD_DATA;
                    end
                end
                ARB_RD_DATA: begin
                    if (s_rvalid && s_rready) begin
                        grant <= GRANT_NONE;
                        state <= ARB_IDLE;
`ifdef YSYX_ARB_ROUND_ROBIN_EN
                        last_owner <= grant[1];
`endif
                    end
                end
                ARB_WR_ADDR: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        state <= ARB_WR_RESP;
                    end
                end
                ARB_WR_RESP: begin
                    if (s_bvalid && s_bready) begin
                        grant   <= GRANT_NONE;
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ARB_IDLE;
`ifdef YSYX_ARB_ROUND_ROBIN_EN
                        last_owner <= grant[1];
`endif
                    end
                end
                default: begin
                    state <= ARB_IDLE;
                    grant <= GRANT_NONE;
                end
            endcase
        end
    end

    // Select the owning master's request-side signals from the registered grant
    always_comb begin
        own_araddr  = '0;
        own_arvalid = 1'b0;
        own_rready  = 1'b0;
        own_awaddr  = '0;
        own_awvalid = 1'b0;
        own_wdata   = '0;
        own_wstrb   = '0;
        own_wvalid  = 1'b0;
        own_bready  = 1'b0;
        if (grant == DATAMEM_GRANT) begin
            own_araddr  = m1_araddr;
            own_arvalid = m1_arvalid;
            own_rready  = m1_rready;
            own_awaddr  = m1_awaddr;
            own_awvalid = m1_awvalid;
            own_wdata   = m1_wdata;
            own_wstrb   = m1_wstrb;
            own_wvalid  = m1_wvalid;
            own_bready  = m1_bready;
        end else if (grant == IFU_GRANT) begin
            own_araddr  = m0_araddr;
            own_arvalid = m0_arvalid;
            own_rready  = m0_rready;
            own_awaddr  = m0_awaddr;
            own_awvalid = m0_awvalid;
            own_wdata   = m0_wdata;
            own_wstrb   = m0_wstrb;
            own_wvalid  = m0_wvalid;
            own_bready  = m0_bready;
        end
    end

    // Drive the slave; each handshake signal is only live in the phase that owns it
    always_comb begin
        s_araddr  = own_araddr;
        s_awaddr  = own_awaddr;
        s_wdata   = own_wdata;
        s_wstrb   = own_wstrb;
        s_arvalid = (state == ARB_RD_ADDR) && own_arvalid;
        s_rready  = (state == ARB_RD_DATA) && own_rready;
        // once AW or W has handshaken its valid is hidden so the slave never sees it twice
        s_awvalid = (state == ARB_WR_ADDR) && !aw_done && own_awvalid;
        s_wvalid  = (state == ARB_WR_ADDR) && !w_done && own_wvalid;
        s_bready  = (state == ARB_WR_RESP) && own_bready;
    end

    // Return slave responses to the owning master only; the other master sees zeros
    always_comb begin
        m0_arready = grant[0] && (state == ARB_RD_ADDR) && s_arready;
        m0_rvalid  = grant[0] && (state == ARB_RD_DATA) && s_rvalid;
        m0_rdata   = grant[0] ? s_rdata : '0;
        m0_rresp   = grant[0] ? s_rresp : '0;
        m0_awready = grant[0] && (state == ARB_WR_ADDR) && !aw_done && s_awready;
        m0_wready  = grant[0] && (state == ARB_WR_ADDR) && !w_done && s_wready;
        m0_bvalid  = grant[0] && (state == ARB_WR_RESP) && s_bvalid;
        m0_bresp   = grant[0] ? s_bresp : '0;

        m1_arready = grant[1] && (state == ARB_RD_ADDR) && s_arready;
        m1_rvalid  = grant[1] && (state == ARB_RD_DATA) && s_rvalid;
        m1_rdata   = grant[1] ? s_rdata : '0;
        m1_rresp   = grant[1] ? s_rresp : '0;
        m1_awready = grant[1] && (state == ARB_WR_ADDR) && !aw_done && s_awready;
        m1_wready  = grant[1] && (state == ARB_WR_ADDR) && !w_done && s_wready;
        m1_bvalid  = grant[1] && (state == ARB_WR_RESP) && s_bvalid;
        m1_bresp   = grant[1] ? s_bresp : '0;
    end

endmodule

// File: tb/tb_axi_lite_bus_arbiter.sv
// Bench for axi_lite_bus_arbiter: directed master traffic, behavioural slave, scoreboard monitor.
// Latency: n/a.
// Backpressure: slave model inserts configurable ready/valid delays.
module tb_axi_lite_bus_arbiter;
    import axi_lite_bus_arbiter_pkg::*;

    logic        clk;
    logic        resetn;

    logic [31:0] m_araddr [2];
    logic        m_arvalid[2];
    logic        m_arready[2];
    logic [31:0] m_rdata  [2];
    logic [1:0]  m_rresp  [2];
    logic        m_rvalid [2];
    logic        m_rready [2];
    logic [31:0] m_awaddr [2];
    logic        m_awvalid[2];
    logic        m_awready[2];
    logic [31:0] m_wdata  [2];
    logic [3:0]  m_wstrb  [2];
    logic        m_wvalid [2];
    logic        m_wready [2];
    logic [1:0]  m_bresp  [2];
    logic        m_bvalid [2];
    logic        m_bready [2];

    logic [31:0] s_araddr, s_rdata, s_awaddr, s_wdata;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]  s_rresp, s_bresp;
    logic [3:0]  s_wstrb;
    logic [1:0]  grant;

    axi_lite_bus_arbiter dut (
        .clk(clk), .resetn(resetn),
        .m0_araddr(m_araddr[0]), .m0_arvalid(m_arvalid[0]), .m0_arready(m_arready[0]),
        .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m0_awaddr(m_awaddr[0]), .m0_awvalid(m_awvalid[0]), .m0_awready(m_awready[0]),
        .m0_wdata(m_wdata[0]), .m0_wstrb(m_wstrb[0]), .m0_wvalid(m_wvalid[0]), .m0_wready(m_wready[0]),
        .m0_bresp(m_bresp[0]), .m0_bvalid(m_bvalid[0]), .m0_bready(m_bready[0]),
        .m1_araddr(m_araddr[1]), .m1_arvalid(m_arvalid[1]), .m1_arready(m_arready[1]),
        .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .m1_awaddr(m_awaddr[1]), .m1_awvalid(m_awvalid[1]), .m1_awready(m_awready[1]),
        .m1_wdata(m_wdata[1]), .m1_wstrb(m_wstrb[1]), .m1_wvalid(m_wvalid[1]), .m1_wready(m_wready[1]),
        .m1_bresp(m_bresp[1]), .m1_bvalid(m_bvalid[1]), .m1_bready(m_bready[1]),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // slave job: d_a = AR (or AW) ready delay, d_b = R valid (or W ready) delay
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [1:0]  resp;
        int          d_a;
        int          d_b;
    } job_t;

    typedef struct {
        int          m;
        bit          wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    job_t slave_q[$];
    exp_t resp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    int   iso_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_rd(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [1:0] resp, input int d_a, input int d_b, input bit exp_resp);
        job_t j;
        exp_t e;
        j.wr = 1'b0; j.addr = addr; j.data = data; j.strb = 4'h0; j.resp = resp; j.d_a = d_a; j.d_b = d_b;
        slave_q.push_back(j);
        if (exp_resp) begin
            e.m = m; e.wr = 1'b0; e.data = data; e.resp = resp;
            resp_q.push_back(e);
        end
    endtask

    task automatic push_wr(input int m, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] resp, input int d_a, input int d_b);
        job_t j;
        exp_t e;
        j.wr = 1'b1; j.addr = addr; j.data = data; j.strb = strb; j.resp = resp; j.d_a = d_a; j.d_b = d_b;
        slave_q.push_back(j);
        e.m = m; e.wr = 1'b1; e.data = 32'h0; e.resp = resp;
        resp_q.push_back(e);
    endtask

    // ---------------- master drivers ----------------
    task automatic master_read(input int m, input logic [31:0] addr);
        bit hs;
        hs = 1'b0;
        m_araddr[m]  = addr;
        m_arvalid[m] = 1'b1;
        for (int i = 0; i < 300 && !hs; i++) begin
            @(negedge clk);
            hs = m_arready[m];
        end
        chk("master_ar_handshake", 32'(hs), 32'd1);
        @(posedge clk); #1;
        m_arvalid[m] = 1'b0;
        m_araddr[m]  = 32'h0;
    endtask

    task automatic master_write(input int m, input logic [31:0] addr, input logic [31:0] data,
                                input logic [3:0] strb);
        bit aw_ok, w_ok, a, w;
        aw_ok = 1'b0; w_ok = 1'b0;
        m_awaddr[m] = addr; m_awvalid[m] = 1'b1;
        m_wdata[m]  = data; m_wstrb[m]   = strb; m_wvalid[m] = 1'b1;
        for (int i = 0; i < 300 && !(aw_ok && w_ok); i++) begin
            @(negedge clk);
            a = m_awvalid[m] && m_awready[m];
            w = m_wvalid[m] && m_wready[m];
            @(posedge clk); #1;
            if (a) begin aw_ok = 1'b1; m_awvalid[m] = 1'b0; end
            if (w) begin w_ok = 1'b1; m_wvalid[m] = 1'b0; end
        end
        chk("master_aw_handshake", 32'(aw_ok), 32'd1);
        chk("master_w_handshake", 32'(w_ok), 32'd1);
    endtask

    // ---------------- behavioural slave ----------------
    task automatic s_clear();
        s_arready = 1'b0; s_rvalid = 1'b0; s_rdata = 32'h0; s_rresp = 2'b00;
        s_awready = 1'b0; s_wready = 1'b0; s_bvalid = 1'b0; s_bresp = 2'b00;
    endtask

    task automatic slave_read();
        job_t j;
        bit   ab, hs;
        ab = 1'b0; hs = 1'b0;
        chk("slave_job_available", 32'(slave_q.size() != 0), 32'd1);
        if (slave_q.size() != 0) j = slave_q.pop_front();
        else begin j.wr = 1'b0; j.addr = 32'h0; j.data = 32'h0; j.strb = 4'h0; j.resp = 2'b00; j.d_a = 0; j.d_b = 0; end
        chk("slave_job_is_read", 32'(j.wr), 32'd0);
        repeat (j.d_a) @(negedge clk);
        @(posedge clk); #1;
        s_arready = 1'b1;
        @(negedge clk);
        chk("s_araddr", s_araddr, j.addr);
        @(posedge clk); #1;
        s_arready = 1'b0;
        for (int i = 0; i < j.d_b && !ab; i++) begin
            @(negedge clk);
            if (!resetn) ab = 1'b1;
            else begin @(posedge clk); #1; end
        end
        if (ab) begin s_clear(); return; end
        s_rvalid = 1'b1; s_rdata = j.data; s_rresp = j.resp;
        for (int i = 0; i < 60 && !hs && !ab; i++) begin
            @(negedge clk);
            if (!resetn) ab = 1'b1;
            else hs = s_rready;
        end
        if (!ab) chk("slave_r_handshake", 32'(hs), 32'd1);
        @(posedge clk); #1;
        s_clear();
    endtask

    task automatic slave_write();
        job_t j;
        int   aw_n, w_n, cyc;
        bit   ab, hs;
        aw_n = 0; w_n = 0; cyc = 0; ab = 1'b0; hs = 1'b0;
        chk("slave_job_available", 32'(slave_q.size() != 0), 32'd1);
        if (slave_q.size() != 0) j = slave_q.pop_front();
        else begin j.wr = 1'b1; j.addr = 32'h0; j.data = 32'h0; j.strb = 4'h0; j.resp = 2'b00; j.d_a = 0; j.d_b = 0; end
        chk("slave_job_is_write", 32'(j.wr), 32'd1);
        // readies stay high once opened, so an unmasked repeat valid would be counted twice
        while (!(aw_n > 0 && w_n > 0) && cyc < 60 && !ab) begin
            @(posedge clk); #1;
            s_awready = (cyc >= j.d_a);
            s_wready  = (cyc >= j.d_b);
            @(negedge clk);
            if (!resetn) ab = 1'b1;
            if (s_awvalid && s_awready) begin
                aw_n++;
                chk("s_awaddr", s_awaddr, j.addr);
            end
            if (s_wvalid && s_wready) begin
                w_n++;
                chk("s_wdata", s_wdata, j.data);
                chk("s_wstrb", 32'(s_wstrb), 32'(j.strb));
            end
            cyc++;
        end
        if (ab) begin @(posedge clk); #1; s_clear(); return; end
        chk("aw_handshake_count", 32'(aw_n), 32'd1);
        chk("w_handshake_count", 32'(w_n), 32'd1);
        @(posedge clk); #1;
        s_awready = 1'b0; s_wready = 1'b0;
        s_bvalid = 1'b1; s_bresp = j.resp;
        for (int i = 0; i < 60 && !hs; i++) begin
            @(negedge clk);
            hs = s_bready;
        end
        chk("slave_b_handshake", 32'(hs), 32'd1);
        @(posedge clk); #1;
        s_clear();
    endtask

    initial begin
        s_clear();
        forever begin
            @(negedge clk);
            if (!resetn) s_clear();
            else if (s_arvalid) slave_read();
            else if (s_awvalid || s_wvalid) slave_write();
        end
    end

    // ---------------- response monitor / scoreboard ----------------
    task automatic check_resp(input int m, input bit wr, input logic [31:0] data, input logic [1:0] resp);
        exp_t e;
        chk("resp_expected", 32'(resp_q.size() != 0), 32'd1);
        if (resp_q.size() == 0) return;
        e = resp_q.pop_front();
        chk("resp_master", 32'(m), 32'(e.m));
        chk("resp_kind", 32'(wr), 32'(e.wr));
        if (!e.wr) chk("resp_rdata", data, e.data);
        chk("resp_code", 32'(resp), 32'(e.resp));
        chk("resp_grant", 32'(grant), (e.m == 1) ? 32'(DATAMEM_GRANT) : 32'(IFU_GRANT));
    endtask

    logic [1:0] prev_grant;
    initial begin
        prev_grant = 2'b00;
        forever begin
            @(negedge clk);
            if (resetn) begin
                // grant may only go none->owner or owner->none, so every release shows an idle cycle
                if (grant !== prev_grant)
                    chk("grant_sequence", 32'((prev_grant == 2'b00 || grant == 2'b00) && $onehot0(grant)), 32'd1);
                for (int m = 0; m < 2; m++) begin
                    if (grant[m] !== 1'b1 &&
                        (m_arready[m] || m_rvalid[m] || m_awready[m] || m_wready[m] || m_bvalid[m] ||
                         m_rdata[m] != 32'h0 || m_rresp[m] != 2'b00 || m_bresp[m] != 2'b00))
                        iso_err++;
                    if (m_rvalid[m]) check_resp(m, 1'b0, m_rdata[m], m_rresp[m]);
                    if (m_bvalid[m]) check_resp(m, 1'b1, 32'h0, m_bresp[m]);
                end
            end
            prev_grant = grant;
        end
    end

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            @(posedge clk); #2;
            ok = (resp_q.size() == 0) && (slave_q.size() == 0);
        end
        chk("drain", 32'(ok), 32'd1);
        chk("grant_released", 32'(grant), 32'(GRANT_NONE));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        for (int m = 0; m < 2; m++) begin
            m_araddr[m] = 32'h0; m_arvalid[m] = 1'b0; m_rready[m] = 1'b1;
            m_awaddr[m] = 32'h0; m_awvalid[m] = 1'b0;
            m_wdata[m]  = 32'h0; m_wstrb[m]   = 4'h0; m_wvalid[m] = 1'b0; m_bready[m] = 1'b1;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_s_handshakes", 32'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 32'd0);
        chk("rst_m0_handshakes", 32'({m_arready[0], m_rvalid[0], m_awready[0], m_wready[0], m_bvalid[0]}), 32'd0);
        chk("rst_m1_handshakes", 32'({m_arready[1], m_rvalid[1], m_awready[1], m_wready[1], m_bvalid[1]}), 32'd0);
        chk("rst_s_addr_data", s_araddr | s_awaddr | s_wdata, 32'h0);
        @(posedge clk); #1;
        resetn = 1'b1;
        repeat (2) @(posedge clk); #1;

        // tie A: LSU first, then IFU (both builds, last_owner starts at IFU)
        push_rd(1, 32'h1000_0010, 32'h1111_2222, AXI_RESP_OKAY, 0, 0, 1'b1);
        push_rd(0, 32'h8000_0004, 32'h0000_0093, AXI_RESP_OKAY, 1, 0, 1'b1);
        fork
            master_read(0, 32'h8000_0004);
            master_read(1, 32'h1000_0010);
        join
        drain();

        // LSU read answered with SLVERR
        @(posedge clk); #1;
        push_rd(1, 32'h1000_0020, 32'hDEAD_BEEF, AXI_RESP_SLVERR, 1, 1, 1'b1);
        master_read(1, 32'h1000_0020);
        drain();

        // tie B: LSU owned the bus last
        @(posedge clk); #1;
`ifdef YSYX_ARB_ROUND_ROBIN_EN
        push_rd(0, 32'h8000_0014, 32'h0000_0113, AXI_RESP_OKAY, 0, 0, 1'b1);
        push_rd(1, 32'h1000_0030, 32'h5555_AAAA, AXI_RESP_EXSLV, 0, 0, 1'b1);
`else
        push_rd(1, 32'h1000_0030, 32'h5555_AAAA, AXI_RESP_EXSLV, 0, 0, 1'b1);
        push_rd(0, 32'h8000_0014, 32'h0000_0113, AXI_RESP_OKAY, 0, 0, 1'b1);
`endif
        fork
            master_read(0, 32'h8000_0014);
            master_read(1, 32'h1000_0030);
        join
        drain();

        // IFU-only fetch, slave waits two cycles before accepting
        @(posedge clk); #1;
        push_rd(0, 32'h8000_0000, 32'h0000_0513, AXI_RESP_OKAY, 2, 0, 1'b1);
        master_read(0, 32'h8000_0000);
        drain();

        // LSU byte store, W accepted two cycles before AW
        @(posedge clk); #1;
        push_wr(1, 32'hA000_03F8, 32'h0000_0041, 4'b0001, AXI_RESP_OKAY, 2, 0);
        master_write(1, 32'hA000_03F8, 32'h0000_0041, 4'b0001);
        drain();

        // reset while waiting in the read-data phase
        @(posedge clk); #1;
        push_rd(0, 32'h8000_0008, 32'h1234_5678, AXI_RESP_OKAY, 0, 8, 1'b0);
        master_read(0, 32'h8000_0008);
        resetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_grant", 32'(grant), 32'd0);
        chk("midrst_s_handshakes", 32'({s_arvalid, s_rready, s_awvalid, s_wvalid, s_bready}), 32'd0);
        chk("midrst_m_handshakes", 32'({m_arready[0], m_rvalid[0], m_arready[1], m_rvalid[1]}), 32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(posedge clk); #1;
        push_rd(0, 32'h8000_000C, 32'h0000_0297, AXI_RESP_OKAY, 0, 1, 1'b1);
        master_read(0, 32'h8000_000C);
        drain();

        // IFU asks for read and write together: read first, then write (DECERR passed back)
        @(posedge clk); #1;
        push_rd(0, 32'h8000_0010, 32'h00A0_0093, AXI_RESP_OKAY, 0, 0, 1'b1);
        push_wr(0, 32'h8000_0100, 32'hCAFE_F00D, 4'hF, AXI_RESP_DECERR, 1, 1);
        fork
            master_read(0, 32'h8000_0010);
            master_write(0, 32'h8000_0100, 32'hCAFE_F00D, 4'hF);
        join
        drain();

        repeat (3) @(posedge clk);
        chk("non_owner_isolation_errors", 32'(iso_err), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
